// File: rtl/gfe_inv_arbiter.sv
// Round-robin arbiter sharing a two-port GF(3) inverse unit among NREQ requesters.
// Optional statistics counters are enabled by defining GFE_INV_ARB_STATS_EN.
module gfe_inv_arbiter #(
    parameter int NREQ = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NREQ-1:0]   req_valid,
    input  logic [2*NREQ-1:0] req_data,
    output logic [NREQ-1:0]   req_ready,
    output logic [NREQ-1:0]   rsp_valid,
    output logic [2*NREQ-1:0] rsp_data,
    output logic [NREQ-1:0]   rsp_err,
    input  logic [NREQ-1:0]   rsp_ready,
    output logic [1:0]        inv_din_A,
    output logic [1:0]        inv_din_B,
    input  logic [1:0]        inv_dout_A,
    input  logic [1:0]        inv_dout_B,
    input  logic              inv_dout_en_A,
    input  logic              inv_dout_en_B,
    output logic [15:0]       stat_ops,
    output logic [15:0]       stat_errs
);
    localparam int IDW = $clog2(NREQ);

    logic [IDW-1:0]  rr_ptr;
    logic            tag_a_vld, tag_b_vld;
    logic            tag_a_ill, tag_b_ill;
    logic [IDW-1:0]  tag_a_id, tag_b_id;
    logic [1:0]      operand   [NREQ];
    logic [1:0]      slot_data [NREQ];
    logic [NREQ-1:0] in_flight;
    logic [NREQ-1:0] eligible;
    logic            gnt_a_vld, gnt_b_vld;
    logic [IDW-1:0]  gnt_a_id, gnt_b_id;
    logic [1:0]      op_a, op_b;

    for (genvar g = 0; g < NREQ; g++) begin : g_unpack
        assign operand[g]           = req_data[2*g +: 2];
        assign rsp_data[2*g +: 2]   = slot_data[g];
    end

    function automatic logic [IDW-1:0] wrap_inc(input logic [IDW-1:0] id);
        return (id == IDW'(NREQ - 1)) ? '0 : id + 1'b1;
    endfunction

    always_comb begin
        for (int unsigned i = 0; i < NREQ; i++) begin
            in_flight[i] = (tag_a_vld && tag_a_id == IDW'(i)) ||
                           (tag_b_vld && tag_b_id == IDW'(i));
        end
    end

    // A requester holds at most one op: blocked while in flight or while its slot is full.
    assign eligible = req_valid & ~in_flight & ~rsp_valid;

    always_comb begin
        int unsigned idx;
        idx       = 0;
        gnt_a_vld = 1'b0;
        gnt_b_vld = 1'b0;
        gnt_a_id  = '0;
        gnt_b_id  = '0;
        for (int unsigned k = 0; k < NREQ; k++) begin
            idx = 32'(rr_ptr) + k;
            if (idx >= NREQ) idx = idx - NREQ;
            if (eligible[IDW'(idx)]) begin
                if (!gnt_a_vld) begin
                    gnt_a_vld = 1'b1;
                    gnt_a_id  = IDW'(idx);
                end else if (!gnt_b_vld) begin
                    gnt_b_vld = 1'b1;
                    gnt_b_id  = IDW'(idx);
                end
            end
        end
    end

    always_comb begin
        for (int unsigned i = 0; i < NREQ; i++) begin
            req_ready[i] = (gnt_a_vld && gnt_a_id == IDW'(i)) ||
                           (gnt_b_vld && gnt_b_id == IDW'(i));
        end
    end

    assign op_a      = operand[gnt_a_id];
    assign op_b      = operand[gnt_b_id];
    assign inv_din_A = (gnt_a_vld && op_a != 2'b11) ? op_a : 2'b00;
    assign inv_din_B = (gnt_b_vld && op_b != 2'b11) ? op_b : 2'b00;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr    <= '0;
            tag_a_vld <= 1'b0;
            tag_b_vld <= 1'b0;
            tag_a_ill <= 1'b0;
            tag_b_ill <= 1'b0;
            tag_a_id  <= '0;
            tag_b_id  <= '0;
        end else begin
            tag_a_vld <= gnt_a_vld;
            tag_b_vld <= gnt_b_vld;
            tag_a_id  <= gnt_a_id;
            tag_b_id  <= gnt_b_id;
            tag_a_ill <= gnt_a_vld && op_a == 2'b11;
            tag_b_ill <= gnt_b_vld && op_b == 2'b11;
            if (gnt_b_vld)      rr_ptr <= wrap_inc(gnt_b_id);
            else if (gnt_a_vld) rr_ptr <= wrap_inc(gnt_a_id);
        end
    end

    // Capture and release never target the same slot, so the order below is not a priority.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_valid <= '0;
            rsp_err   <= '0;
            for (int unsigned i = 0; i < NREQ; i++) slot_data[i] <= 2'b00;
        end else begin
            for (int unsigned i = 0; i < NREQ; i++) begin
                if (tag_a_vld && tag_a_id == IDW'(i)) begin
                    rsp_valid[i] <= 1'b1;
                    slot_data[i] <= tag_a_ill ? 2'b00 : inv_dout_A;
                    rsp_err[i]   <= tag_a_ill | ~inv_dout_en_A;
                end else if (tag_b_vld && tag_b_id == IDW'(i)) begin
                    rsp_valid[i] <= 1'b1;
                    slot_data[i] <= tag_b_ill ? 2'b00 : inv_dout_B;
                    rsp_err[i]   <= tag_b_ill | ~inv_dout_en_B;
                end else if (rsp_valid[i] && rsp_ready[i]) begin
                    rsp_valid[i] <= 1'b0;
                end
            end
        end
    end

`ifdef GFE_INV_ARB_STATS_EN
    logic [1:0] n_acc, n_err;

    function automatic logic [15:0] sat_add(input logic [15:0] a, input logic [1:0] b);
        logic [16:0] s;
        s = {1'b0, a} + {15'b0, b};
        return s[16] ? 16'hFFFF : s[15:0];
    endfunction

    always_comb begin
        n_acc = {1'b0, gnt_a_vld} + {1'b0, gnt_b_vld};
        n_err = {1'b0, tag_a_vld && (tag_a_ill || !inv_dout_en_A)} +
                {1'b0, tag_b_vld && (tag_b_ill || !inv_dout_en_B)};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stat_ops  <= '0;
            stat_errs <= '0;
        end else begin
            stat_ops  <= sat_add(stat_ops, n_acc);
            stat_errs <= sat_add(stat_errs, n_err);
        end
    end
`else
    assign stat_ops  = '0;
    assign stat_errs = '0;
`endif

endmodule
